mtimer_irq_unit: RTL and testbench

- Memory-mapped RISC-V machine timer (mtime/mtimecmp) that sits beside the data-memory port of the 3-stage processor.
- Load/store accesses decoded to its address window reach it through a one-cycle registered read interface.
- It produces a level machine-timer interrupt that feeds the CSR register file (mip.MTIP) for trap generation in the writeback stage.

---
 rtl/mtimer_irq_unit.sv | 110 +++++++++++
 tb/tb_mtimer_irq_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mtimer_irq_unit.sv
// Memory-mapped RISC-V machine timer (mtime/mtimecmp) with a registered
// load/store port and a level machine-timer interrupt for mip.MTIP.
module mtimer_irq_unit #(
  parameter int unsigned  PRESCALE  = 1,
  parameter logic [63:0]  CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        halt,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        acc_err,
  output logic        timer_irq
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [15:0] prescale_cnt;
  logic [31:0] hi_shadow;

  logic        aligned;
  logic        wr;
  logic        rd;
  logic        tick;
  logic        wr_mtime;
  logic [63:0] mtime_next;
  logic [15:0] prescale_next;
  logic [31:0] rd_mux;

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign aligned  = (addr[1:0] == 2'b00);
  assign wr       = sel && wr_en && aligned;
  assign rd       = sel && rd_en && aligned;
  assign tick     = !halt && (prescale_cnt == PS_LAST);
  assign wr_mtime = wr && !addr[3];

  // A software write to one mtime half beats a same-cycle tick; the other half keeps its pre-tick value.
  always_comb begin
    mtime_next    = tick ? mtime + 64'd1 : mtime;
    prescale_next = prescale_cnt;
    if (!halt) prescale_next = tick ? 16'd0 : prescale_cnt + 16'd1;
    if (wr_mtime) begin
      prescale_next = 16'd0;
      if (addr[2]) mtime_next = {merge(mtime[63:32], wdata, wmask), mtime[31:0]};
      else         mtime_next = {mtime[63:32], merge(mtime[31:0], wdata, wmask)};
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (addr[3:2])
      2'd0: rd_mux = mtime[31:0];
      2'd1: rd_mux = hi_shadow;
      2'd2: rd_mux = mtimecmp[31:0];
      2'd3: rd_mux = mtimecmp[63:32];
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime        <= 64'd0;
      prescale_cnt <= 16'd0;
      mtimecmp     <= CMP_RESET;
    end else begin
      mtime        <= mtime_next;
      prescale_cnt <= prescale_next;
      if (wr && addr[3] && !addr[2]) mtimecmp[31:0]  <= merge(mtimecmp[31:0], wdata, wmask);
      if (wr && addr[3] &&  addr[2]) mtimecmp[63:32] <= merge(mtimecmp[63:32], wdata, wmask);
    end
  end

  // Reading mtime_lo snapshots the high half so a following mtime_hi read is coherent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata     <= 32'd0;
      rvalid    <= 1'b0;
      acc_err   <= 1'b0;
      hi_shadow <= 32'd0;
      timer_irq <= 1'b0;
    end else begin
      rvalid    <= rd;
      acc_err   <= sel && (rd_en || wr_en) && !aligned;
      timer_irq <= (mtime >= mtimecmp);
      if (rd) begin
        rdata <= rd_mux;
        if (addr[3:2] == 2'd0) hi_shadow <= mtime[63:32];
      end
    end
  end

endmodule

// File: tb/tb_mtimer_irq_unit.sv
// Directed bench for mtimer_irq_unit: one instance at PRESCALE=1 and one at
// PRESCALE=4, sharing the bus signals but with separate select/halt.
module tb_mtimer_irq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel, sel4;
  logic        wr_en, rd_en;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        halt, halt4;
  logic [31:0] rdata, rdata4;
  logic        rvalid, rvalid4;
  logic        acc_err, acc_err4;
  logic        timer_irq, timer_irq4;

  int checks   = 0;
  int failures = 0;

  mtimer_irq_unit #(.PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .sel(sel), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .wmask(wmask), .halt(halt),
    .rdata(rdata), .rvalid(rvalid), .acc_err(acc_err), .timer_irq(timer_irq)
  );

  mtimer_irq_unit #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .sel(sel4), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .wmask(wmask), .halt(halt4),
    .rdata(rdata4), .rvalid(rvalid4), .acc_err(acc_err4), .timer_irq(timer_irq4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; drives one bus cycle and returns at the next negedge.
  task automatic applyStimulus(input logic toDut4, input logic doRd, input logic doWr,
                               input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    if (toDut4) sel4 = 1'b1; else sel = 1'b1;
    rd_en = doRd; wr_en = doWr; addr = a; wdata = d; wmask = m;
    @(negedge clk);
    sel = 1'b0; sel4 = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; sel4 = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    addr = 4'h0; wdata = 32'h0; wmask = 4'h0; halt = 1'b0; halt4 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_rvalid", rvalid, 0);
    checkOutput("reset_acc_err", acc_err, 0);
    checkOutput("reset_irq", timer_irq, 0);
    checkOutput("reset_rdata", rdata, 0);
    rst = 1'b1;

    // Free running count at PRESCALE=1
    repeat (10) @(negedge clk);
    applyStimulus(0, 1, 0, 4'h0, 0, 0);
    checkOutput("count10_rvalid", rvalid, 1);
    checkOutput("count10_rdata", rdata, 32'hA);
    checkOutput("count10_irq", timer_irq, 0);
    @(negedge clk);
    checkOutput("rvalid_single_pulse", rvalid, 0);

    // PRESCALE=4 with a halt frozen mid-count (cnt=2)
    applyStimulus(1, 0, 1, 4'h0, 32'h0, 4'hF);
    repeat (42) @(negedge clk);
    halt4 = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(1, 1, 0, 4'h0, 0, 0);
    checkOutput("ps4_halted_rvalid", rvalid4, 1);
    checkOutput("ps4_halted_mtime", rdata4, 32'd10);
    halt4 = 1'b0;
    @(negedge clk);
    applyStimulus(1, 1, 0, 4'h0, 0, 0);
    checkOutput("ps4_resume_a", rdata4, 32'd10);
    applyStimulus(1, 1, 0, 4'h0, 0, 0);
    checkOutput("ps4_resume_b", rdata4, 32'd11);

    // Compare match: mtime=2 after the three writes, reaches 0x20 thirty edges later
    applyStimulus(0, 0, 1, 4'h0, 32'h0, 4'hF);
    applyStimulus(0, 0, 1, 4'hC, 32'h0, 4'hF);
    applyStimulus(0, 0, 1, 4'h8, 32'h20, 4'hF);
    repeat (30) @(negedge clk);
    checkOutput("irq_before_match", timer_irq, 0);
    @(negedge clk);
    checkOutput("irq_rise", timer_irq, 1);
    applyStimulus(0, 0, 1, 4'h8, 32'h100, 4'hF);
    checkOutput("irq_lag_after_cmp_write", timer_irq, 1);
    @(negedge clk);
    checkOutput("irq_fall", timer_irq, 0);

    // Write/tick priority and hi shadow coherence
    applyStimulus(0, 0, 1, 4'h0, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(0, 0, 1, 4'h4, 32'h0, 4'hF);
    @(negedge clk);
    applyStimulus(0, 1, 0, 4'h0, 0, 0);
    checkOutput("lo_after_carry", rdata, 32'h0);
    applyStimulus(0, 0, 1, 4'h4, 32'h5, 4'hF);
    applyStimulus(0, 1, 0, 4'h4, 0, 0);
    checkOutput("hi_from_shadow", rdata, 32'h1);
    applyStimulus(0, 1, 0, 4'h0, 0, 0);
    checkOutput("lo_no_carry_on_hi_write", rdata, 32'h2);
    applyStimulus(0, 1, 0, 4'h4, 0, 0);
    checkOutput("hi_after_write", rdata, 32'h5);

    // Byte-masked store and misaligned accesses
    applyStimulus(0, 0, 1, 4'h8, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(0, 0, 1, 4'h8, 32'hAABB_CCDD, 4'b0010);
    applyStimulus(0, 1, 0, 4'h8, 0, 0);
    checkOutput("masked_store", rdata, 32'hFFFF_CCFF);
    applyStimulus(0, 0, 1, 4'h2, 32'h0, 4'hF);
    checkOutput("misalign_wr_err", acc_err, 1);
    checkOutput("misalign_wr_rvalid", rvalid, 0);
    checkOutput("misalign_wr_rdata", rdata, 32'hFFFF_CCFF);
    applyStimulus(0, 1, 0, 4'hA, 0, 0);
    checkOutput("misalign_rd_err", acc_err, 1);
    checkOutput("misalign_rd_rvalid", rvalid, 0);
    @(negedge clk);
    checkOutput("acc_err_pulse_end", acc_err, 0);
    applyStimulus(0, 1, 0, 4'h8, 0, 0);
    checkOutput("misalign_no_change", rdata, 32'hFFFF_CCFF);

    // Bus activity with sel low is ignored
    wr_en = 1'b1; rd_en = 1'b1; addr = 4'h8; wdata = 32'h0; wmask = 4'hF;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    checkOutput("unselected_rvalid", rvalid, 0);
    applyStimulus(0, 1, 0, 4'h8, 0, 0);
    checkOutput("unselected_no_write", rdata, 32'hFFFF_CCFF);

    // Read and write at the same offset: read sees the old value
    applyStimulus(0, 1, 1, 4'h8, 32'h1234_5678, 4'hF);
    checkOutput("rw_same_old", rdata, 32'hFFFF_CCFF);
    applyStimulus(0, 1, 0, 4'h8, 0, 0);
    checkOutput("rw_same_committed", rdata, 32'h1234_5678);
    checkOutput("irq_high_before_reset", timer_irq, 1);

    // Asynchronous reset between a read request and its response
    sel = 1'b1; rd_en = 1'b1; addr = 4'h0;
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_irq", timer_irq, 0);
    checkOutput("async_reset_rvalid", rvalid, 0);
    @(negedge clk);
    sel = 1'b0; rd_en = 1'b0;
    checkOutput("reset_dropped_read", rvalid, 0);
    checkOutput("reset_rdata_cleared", rdata, 0);
    rst = 1'b1;
    applyStimulus(0, 1, 0, 4'h0, 0, 0);
    checkOutput("post_reset_rvalid", rvalid, 1);
    applyStimulus(0, 1, 0, 4'h8, 0, 0);
    checkOutput("post_reset_cmp_lo", rdata, 32'hFFFF_FFFF);
    applyStimulus(0, 1, 0, 4'hC, 0, 0);
    checkOutput("post_reset_cmp_hi", rdata, 32'hFFFF_FFFF);
    applyStimulus(0, 1, 0, 4'h0, 0, 0);
    checkOutput("post_reset_mtime", rdata, 32'd3);
    checkOutput("post_reset_irq", timer_irq, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
